// File: rtl/axi_lite_sram.sv
// axi_lite_sram: AXI4-Lite slave backed by an on-chip word array.
// Independent read/write channels, byte-strobed writes, SLVERR on
// out-of-range addresses, and fixed or LFSR-driven response latency.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   awvalid/awready/awaddr    write address channel
//   wvalid/wready/wdata/wstrb write data channel
//   bvalid/bready/bresp       write response channel
//   arvalid/arready/araddr    read address channel
//   rvalid/rready/rdata/rresp read data channel
module axi_lite_sram #(
  parameter int unsigned        ADDR_W     = 32,
  parameter int unsigned        DATA_W     = 32,
  parameter int unsigned        DEPTH_LOG2 = 12,
  parameter logic [ADDR_W-1:0]  BASE_ADDR  = ADDR_W'(32'h8000_0000),
  parameter int unsigned        LAT_MODE   = 0,
  parameter int unsigned        FIXED_LAT  = 0,
  parameter logic [4:0]         LFSR_MASK  = 5'h1f,
  parameter logic [15:0]        LFSR_SEED  = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ADDR_W-1:0]     awaddr,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [1:0]            bresp,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ADDR_W-1:0]     araddr,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [DATA_W-1:0]     rdata,
  output logic [1:0]            rresp
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(1) << (DEPTH_LOG2 + OFF_W);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DELAY, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_DELAY, R_RESP} r_state_t;

  // Address lies inside [BASE_ADDR, BASE_ADDR + SPAN)
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ({1'b0, off} < SPAN);
  endfunction

  // Word index; byte-offset bits are dropped
  function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return DEPTH_LOG2'((a - BASE_ADDR) >> OFF_W);
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  // Latency source: free-running Fibonacci LFSR, taps 16,14,13,11
  logic [15:0] lfsr;
  logic [4:0]  w_lat;
  logic [4:0]  r_lat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= LFSR_SEED;
    else      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign w_lat = (LAT_MODE == 0) ? 5'(FIXED_LAT) : (lfsr[4:0] & LFSR_MASK);
  assign r_lat = (LAT_MODE == 0) ? 5'(FIXED_LAT) : (lfsr[12:8] & LFSR_MASK);

  // ---------------- write channel ----------------
  w_state_t            w_state;
  logic                aw_got;
  logic                w_got;
  logic [ADDR_W-1:0]   aw_addr_q;
  logic [DATA_W-1:0]   w_data_q;
  logic [STRB_W-1:0]   w_strb_q;
  logic [4:0]          w_cnt;

  logic                aw_hs;
  logic                w_hs;
  logic                have_aw;
  logic                have_w;
  logic                w_complete;
  logic                w_enter_resp;
  logic                w_in_range;
  logic                w_commit;
  logic [ADDR_W-1:0]   w_addr_cur;
  logic [DATA_W-1:0]   w_data_cur;
  logic [STRB_W-1:0]   w_strb_cur;
  logic [DEPTH_LOG2-1:0] w_idx;

  // A beat still on the bus this cycle is used directly so L=0 commits in time
  always_comb begin
    aw_hs        = awvalid & awready;
    w_hs         = wvalid & wready;
    have_aw      = aw_got | aw_hs;
    have_w       = w_got | w_hs;
    w_addr_cur   = aw_got ? aw_addr_q : awaddr;
    w_data_cur   = w_got ? w_data_q : wdata;
    w_strb_cur   = w_got ? w_strb_q : wstrb;
    w_complete   = (w_state == W_IDLE) && have_aw && have_w;
    w_enter_resp = (w_complete && (w_lat == 5'd0)) ||
                   ((w_state == W_DELAY) && (w_cnt == 5'd1));
    w_in_range   = in_range(w_addr_cur);
    w_commit     = w_enter_resp && w_in_range;
    w_idx        = word_idx(w_addr_cur);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state   <= W_IDLE;
      aw_got    <= 1'b0;
      w_got     <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      w_cnt     <= 5'd0;
      awready   <= 1'b0;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bresp     <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_addr_q <= awaddr;
        aw_got    <= 1'b1;
      end
      if (w_hs) begin
        w_data_q <= wdata;
        w_strb_q <= wstrb;
        w_got    <= 1'b1;
      end
      case (w_state)
        W_IDLE: begin
          awready <= ~have_aw;
          wready  <= ~have_w;
          if (w_complete && !w_enter_resp) begin
            w_state <= W_DELAY;
            w_cnt   <= w_lat;
          end
        end
        W_DELAY: begin
          if (!w_enter_resp) w_cnt <= w_cnt - 5'd1;
        end
        W_RESP: begin
          if (bready) begin
            w_state <= W_IDLE;
            bvalid  <= 1'b0;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
          end
        end
        default: w_state <= W_IDLE;
      endcase
      if (w_enter_resp) begin
        w_state <= W_RESP;
        bvalid  <= 1'b1;
        bresp   <= w_in_range ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // Array is not reset; commit only on the edge entering W_RESP
  always_ff @(posedge clk) begin
    if (rst && w_commit) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (w_strb_cur[i]) mem[w_idx][8*i +: 8] <= w_data_cur[8*i +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  r_state_t            r_state;
  logic [ADDR_W-1:0]   ar_addr_q;
  logic [4:0]          r_cnt;

  logic                ar_hs;
  logic                r_enter_resp;
  logic                r_in_range;
  logic [ADDR_W-1:0]   r_addr_cur;
  logic [DEPTH_LOG2-1:0] r_idx;

  always_comb begin
    ar_hs        = arvalid & arready;
    r_addr_cur   = (r_state == R_IDLE) ? araddr : ar_addr_q;
    r_enter_resp = (ar_hs && (r_lat == 5'd0)) ||
                   ((r_state == R_DELAY) && (r_cnt == 5'd1));
    r_in_range   = in_range(r_addr_cur);
    r_idx        = word_idx(r_addr_cur);
  end

  // mem is read with pre-edge contents, so a same-edge write is not visible
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= R_IDLE;
      ar_addr_q <= '0;
      r_cnt     <= 5'd0;
      arready   <= 1'b0;
      rvalid    <= 1'b0;
      rdata     <= '0;
      rresp     <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          arready <= ~ar_hs;
          if (ar_hs) begin
            ar_addr_q <= araddr;
            if (!r_enter_resp) begin
              r_state <= R_DELAY;
              r_cnt   <= r_lat;
            end
          end
        end
        R_DELAY: begin
          if (!r_enter_resp) r_cnt <= r_cnt - 5'd1;
        end
        R_RESP: begin
          if (rready) begin
            r_state <= R_IDLE;
            rvalid  <= 1'b0;
          end
        end
        default: r_state <= R_IDLE;
      endcase
      if (r_enter_resp) begin
        r_state <= R_RESP;
        rvalid  <= 1'b1;
        rdata   <= r_in_range ? mem[r_idx] : '0;
        rresp   <= r_in_range ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

endmodule

// File: doc/axi_lite_sram.md
# axi_lite_sram

Parametrised AXI4-Lite memory slave that replaces the DPI-backed data memory model in the multicycle core's memory stage with a synthesizable on-chip word array. It has independent read and write channels and byte-strobed writes. Address-range checking returns SLVERR. Valid and response signals are held correctly under backpressure. Response latency is either fixed or pseudo-random, for stress-testing the core's LSU and IFU handshakes.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; must be 32 or 64
- DEPTH_LOG2, 12, log2 of the number of words
- BASE_ADDR, 32'h8000_0000, byte address of word 0; must be aligned to DEPTH×(DATA_W/8)
- LAT_MODE, 0, latency source: 0 = fixed, 1 = LFSR
- FIXED_LAT, 0, latency L in cycles when LAT_MODE=0; range 0..31
- LFSR_MASK, 5'h1f, AND-mask applied to the LFSR latency sample
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  asynchronous, active-low reset
- awvalid/awready  in/out  1  write address handshake; awaddr  in  ADDR_W
- wvalid/wready  in/out  1  write data handshake; wdata  in  DATA_W; wstrb  in  DATA_W/8
- bvalid/bready  out/in  1  write response handshake; bresp  out  2
- arvalid/arready  in/out  1  read address handshake; araddr  in  ADDR_W
- rvalid/rready  out/in  1  read data handshake; rdata  out  DATA_W; rresp  out  2

## Operation
- **Address decode**
  - off = addr − BASE_ADDR.
  - The access is in range iff addr ≥ BASE_ADDR and off < DEPTH×(DATA_W/8).
  - Word index = off >> log2(DATA_W/8). Low byte-offset bits are ignored.
- **Write FSM (W_IDLE → W_DELAY → W_RESP)**
  - In W_IDLE, awready=1 until the AW beat is captured, and wready=1 until the W beat is captured.
  - AW and W are accepted independently, in either order or in the same cycle.
  - The cycle that captures the second of the two beats is the completing handshake. At that cycle, L is sampled and the FSM enters W_DELAY, or goes directly to W_RESP when L=0.
  - Commit happens on the edge entering W_RESP:
    - In range: write each byte lane i where wstrb[i]=1; bresp=2'b00.
    - Out of range: discard the write; bresp=2'b10.
  - W_RESP holds bvalid=1 and a stable bresp until bready. On the bready handshake the FSM returns to W_IDLE.
  - awready and wready are 0 in W_DELAY and W_RESP.
- **Read FSM (R_IDLE → R_DELAY → R_RESP)**
  - arready=1 only in R_IDLE. The ar handshake latches araddr and samples L.
  - On the edge entering R_RESP:
    - In range: rdata = mem[idx]; rresp=2'b00.
    - Out of range: rdata=0; rresp=2'b10.
  - rvalid, rdata and rresp are held stable until rready, then the FSM returns to R_IDLE.
- **Channel independence**
  - The read and write channels run fully in parallel.
  - If a write commit and a read sample hit the same word on the same edge, the read returns the pre-write data.
- **Latency source**
  - LAT_MODE=0: L = FIXED_LAT.
  - LAT_MODE=1: a 16-bit Fibonacci LFSR (taps 16,14,13,11) steps every cycle after reset.
    - Write L = lfsr[4:0] & LFSR_MASK.
    - Read L = lfsr[12:8] & LFSR_MASK.
    - Each is sampled in its own completing handshake cycle.
- **Memory contents** are not reset and are undefined until written.

## Timing
- **Reset (rst=0, asynchronous)**
  - awready, wready, arready, bvalid and rvalid go to 0; bresp, rresp and rdata go to 0.
  - Both FSMs go to IDLE, captured-beat flags clear, and the LFSR loads LFSR_SEED.
  - awready, wready and arready rise on the first rising edge after rst deasserts.
- **Reset mid-transaction** aborts it. A write whose commit edge has not yet occurred leaves memory unchanged.
- **Latency**
  - bvalid rises exactly L+1 cycles after the completing write handshake cycle.
  - rvalid rises exactly L+1 cycles after the ar handshake cycle.
  - With L=0, the response is visible in the cycle after the handshake.
- **Back-to-back transfers**
  - The response handshake cycle returns the FSM to IDLE, so a ready is reasserted the following cycle.
  - Minimum write throughput is therefore one transaction per L+3 cycles; the same holds for reads.
- **Combinational paths**
  - No ready depends combinationally on a valid.
  - All outputs are driven from registers or the FSM state only.

## Test plan
- **Fixed-latency write then read:** LAT_MODE=0, FIXED_LAT=3.
  - Write awaddr=0x8000_0010, wdata=0xDEADBEEF, wstrb=4'hF with AW and W in the same cycle → bvalid rises 4 cycles later with bresp=0.
  - Then read araddr=0x8000_0010 → rvalid 4 cycles after the ar handshake, rdata=0xDEADBEEF, rresp=0.
- **Byte strobes:**
  - Write 0x11223344 with wstrb=4'hF, then write 0xAABBCCDD with wstrb=4'b0101 to the same address → read returns 0x11BB33DD.
- **Split AW/W with backpressure:**
  - Send W 5 cycles before AW → wready drops after the W beat, and no bvalid appears until the AW handshake.
  - Hold bready=0 for 7 cycles → bvalid and bresp stay stable, and awready stays 0 throughout.
- **Out of range:**
  - Write to 0x7FFF_FFFC → bresp=2'b10 and memory unchanged.
  - Read from BASE_ADDR + DEPTH×4 → rresp=2'b10, rdata=0.
- **LFSR stress:** LAT_MODE=1, 1000 random interleaved reads and writes with random rready/bready.
  - Every read matches the scoreboard.
  - Every latency is ≤ 32 cycles.
  - No valid drops before its handshake.
- **Reset mid-write:**
  - Assert rst in W_DELAY with FIXED_LAT=10 → bvalid=0 immediately and the target word keeps its old value.
  - Readies rise on the first edge after rst deasserts.
